// File: rtl/lsu_ctrl.sv
`timescale 1ns/1ps
// lsu_ctrl: load/store control stage between EXU and the data memory.
// Takes one request at a time from EXU, checks func3 legality and alignment,
// issues a word-aligned MEM request with byte-lane mask and lane-replicated
// store data, waits for the memory response, and returns sign/zero-extended
// load data (or an error) to WBU through a valid/ready handshake.
//
// Ports:
//   clock, reset (async, active-low)
//   in_*  : EXU request (valid/ready, ren, wen, func3, addr, wdata, tag)
//   mem_* : MEM request (valid/ready, wen, wmask, addr, wdata) and response
//           (rvalid, rdata)
//   out_* : WBU result (valid/ready, rdata, tag, err)
//
// Build option: define LSU_TIMEOUT_EN to add a WAIT-state watchdog that ends
// the transaction with out_err=1 after TIMEOUT cycles without mem_rvalid.
//
// state | meaning
// IDLE  | ready for a new request
// REQ   | memory request driven, waiting for mem_ready
// WAIT  | request granted, waiting for mem_rvalid
// RESP  | result presented to WBU, waiting for out_ready
module lsu_ctrl #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_ren,
  input  logic             in_wen,
  input  logic [2:0]       in_func3,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_wdata,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             mem_wen,
  output logic [7:0]       mem_wmask,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rdata,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [2:0]         func3_q, func3_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               wen_q, wen_d;
  logic               err_q, err_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Request decode, evaluated on the EXU inputs while in IDLE.
  logic f3_legal, misaligned, req_noop, req_err;
  always_comb begin
    f3_legal = 1'b0;
    case (in_func3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = in_ren & ~in_wen;  // unsigned forms are load-only
      default:                f3_legal = 1'b0;
    endcase
    misaligned = ((in_func3[1:0] == 2'b01) & in_addr[0]) |
                 ((in_func3[1:0] == 2'b10) & (in_addr[1:0] != 2'b00));
    req_noop   = ~in_ren & ~in_wen;
    req_err    = (in_ren & in_wen) | ~f3_legal | misaligned;
  end

  // Store lane placement and load extraction from the latched request.
  logic [3:0]  lane_mask;
  logic [31:0] lane_data, shifted, load_ext;
  always_comb begin
    case (func3_q[1:0])
      2'b00:   begin lane_mask = 4'b0001 << addr_q[1:0]; lane_data = {4{wdata_q[7:0]}};  end
      2'b01:   begin lane_mask = 4'b0011 << addr_q[1:0]; lane_data = {2{wdata_q[15:0]}}; end
      default: begin lane_mask = 4'b1111;                lane_data = wdata_q;            end
    endcase
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (func3_q)
      3'b000:  load_ext = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    func3_d = func3_q;
    tag_d   = tag_q;
    wen_d   = wen_q;
    err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d  = in_addr;
          wdata_d = in_wdata;
          func3_d = in_func3;
          tag_d   = in_tag;
          wen_d   = in_wen;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          if (req_noop) begin
            state_d = S_RESP;
          end else if (req_err) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = wen_q ? 32'd0 : load_ext;
          state_d = S_RESP;
        end
`ifdef LSU_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
`endif
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      func3_q <= '0;
      tag_q   <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      func3_q <= func3_d;
      tag_q   <= tag_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  logic in_req, in_resp;
  assign in_req  = (state_q == S_REQ);
  assign in_resp = (state_q == S_RESP);

  assign in_ready  = (state_q == S_IDLE);
  assign mem_valid = in_req;
  assign mem_wen   = in_req & wen_q;
  assign mem_wmask = (in_req & wen_q) ? {4'b0000, lane_mask} : 8'd0;
  assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata = (in_req & wen_q) ? lane_data : 32'd0;
  assign out_valid = in_resp;
  assign out_rdata = in_resp ? rdata_q : 32'd0;
  assign out_tag   = in_resp ? tag_q : '0;
  assign out_err   = in_resp & err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
module tb_lsu_ctrl;
  localparam int TAG_W = 5;

  logic             clock;
  logic             reset;
  logic             in_valid, in_ready, in_ren, in_wen;
  logic [2:0]       in_func3;
  logic [31:0]      in_addr, in_wdata;
  logic [TAG_W-1:0] in_tag;
  logic             mem_valid, mem_ready, mem_wen;
  logic [7:0]       mem_wmask;
  logic [31:0]      mem_addr, mem_wdata;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;
  logic             out_valid, out_ready, out_err;
  logic [31:0]      out_rdata;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.TAG_W(TAG_W), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
    .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata), .in_tag(in_tag),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_wmask(mem_wmask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_tag(out_tag), .out_err(out_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: what a request should produce, from the ISA-level rules.
  function automatic void model(input logic ren, input logic wen, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rd, output logic access,
                                output logic err, output logic [7:0] wmask,
                                output logic [31:0] mwd, output logic [31:0] res);
    int unsigned bytes, off, m;
    logic legal;
    logic [31:0] v;
    bytes = 1 << f3[1:0];
    off   = addr % 4;
    if (ren && !wen)      legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else if (wen && !ren) legal = (f3 == 0 || f3 == 1 || f3 == 2);
    else                  legal = 1'b0;
    err    = (ren || wen) && (!legal || (addr % bytes) != 0);
    access = (ren || wen) && !err;
    wmask  = 8'd0;
    mwd    = 32'd0;
    res    = 32'd0;
    if (access && wen) begin
      m     = ((1 << bytes) - 1) << off;
      wmask = 8'(m);
      if (bytes == 1)      mwd = wd[7:0] * 32'h01010101;
      else if (bytes == 2) mwd = wd[15:0] * 32'h00010001;
      else                 mwd = wd;
    end
    if (access && ren) begin
      v = rd >> (8 * off);
      if (bytes == 1) begin
        v = v % 256;
        if (f3 == 0 && v >= 128) v = v - 256;
      end else if (bytes == 2) begin
        v = v % 65536;
        if (f3 == 1 && v >= 32768) v = v - 65536;
      end
      res = v;
    end
  endfunction

  task automatic txn(input logic ren, input logic wen, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                     input logic [TAG_W-1:0] tag, input int rdy_dly, input int rv_dly,
                     input int out_dly, input string nm);
    logic acc, err;
    logic [7:0] wm;
    logic [31:0] mwd, res;
    model(ren, wen, f3, addr, wd, rd, acc, err, wm, mwd, res);
    check({nm, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_ren = ren; in_wen = wen; in_func3 = f3;
    in_addr = addr; in_wdata = wd; in_tag = tag;
    step();
    in_valid = 1'b0; in_ren = 1'($urandom); in_wen = 1'($urandom);
    in_addr = $urandom; in_wdata = $urandom; in_func3 = 3'($urandom);
    if (acc) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        check({nm, "/mem_valid"}, 32'(mem_valid), 32'd1);
        check({nm, "/mem_addr"},  mem_addr, addr - (addr % 4));
        check({nm, "/mem_wen"},   32'(mem_wen), 32'(wen));
        check({nm, "/mem_wmask"}, 32'(mem_wmask), 32'(wm));
        check({nm, "/mem_wdata"}, mem_wdata, mwd);
        check({nm, "/in_ready_busy"}, 32'(in_ready), 32'd0);
        mem_ready = (i == rdy_dly);
        step();
      end
      mem_ready = 1'b0;
      for (int j = 0; j < rv_dly; j++) begin
        check({nm, "/wait_mem_valid"}, 32'(mem_valid), 32'd0);
        check({nm, "/wait_out_valid"}, 32'(out_valid), 32'd0);
        step();
      end
      mem_rvalid = 1'b1; mem_rdata = rd;
      step();
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end else begin
      check({nm, "/no_mem_valid"}, 32'(mem_valid), 32'd0);
    end
    for (int k = 0; k <= out_dly; k++) begin
      check({nm, "/out_valid"}, 32'(out_valid), 32'd1);
      check({nm, "/out_rdata"}, out_rdata, res);
      check({nm, "/out_tag"},   32'(out_tag), 32'(tag));
      check({nm, "/out_err"},   32'(out_err), 32'(err));
      check({nm, "/in_ready_resp"}, 32'(in_ready), 32'd0);
      out_ready = (k == out_dly);
      step();
    end
    out_ready = 1'b0;
    check({nm, "/out_valid_done"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic ren, wen;
    logic [2:0] f3;
    logic [31:0] addr;
    int kind;

    reset = 1'b0; in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_func3 = 3'd0;
    in_addr = 32'd0; in_wdata = 32'd0; in_tag = '0; mem_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0; out_ready = 1'b0;
    #1;
    check("rst/in_ready",  32'(in_ready), 32'd1);
    check("rst/mem_valid", 32'(mem_valid), 32'd0);
    check("rst/mem_addr",  mem_addr, 32'd0);
    check("rst/mem_wmask", 32'(mem_wmask), 32'd0);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/out_err",   32'(out_err), 32'd0);
    step(); step();
    reset = 1'b1;
    step();

    // Directed cases from the plan.
    txn(1, 0, 3'b000, 32'h80000003, 32'h0, 32'h80FF1234, 5'd3, 0, 0, 0, "lb");
    txn(1, 0, 3'b101, 32'h80000002, 32'h0, 32'h8001ABCD, 5'd4, 0, 0, 0, "lhu");
    txn(0, 1, 3'b000, 32'h80000001, 32'h000000AB, 32'h12345678, 5'd5, 0, 0, 0, "sb");
    txn(1, 0, 3'b010, 32'h80000002, 32'h0, 32'h0, 5'd6, 0, 0, 0, "lw_mis");
    txn(0, 1, 3'b001, 32'h80000001, 32'h1234, 32'h0, 5'd7, 0, 0, 0, "sh_mis");
    txn(1, 0, 3'b010, 32'h80000010, 32'h0, 32'hCAFEF00D, 5'd9, 4, 0, 3, "lw_bp");
    txn(0, 0, 3'b010, 32'h00000004, 32'h0, 32'h0, 5'd10, 0, 0, 1, "noop");
    txn(1, 1, 3'b010, 32'h00000004, 32'h0, 32'h0, 5'd11, 0, 0, 0, "both");
    txn(0, 1, 3'b100, 32'h00000004, 32'h0, 32'h0, 5'd12, 0, 0, 0, "sbu_ill");
    txn(1, 0, 3'b110, 32'h00000004, 32'h0, 32'h0, 5'd13, 0, 0, 0, "ld_ill");
    txn(0, 1, 3'b001, 32'h00000002, 32'hBEEF5A5A, 32'h0, 5'd14, 1, 2, 0, "sh_hi");
    txn(0, 1, 3'b010, 32'h00000008, 32'hDEADBEEF, 32'h0, 5'd15, 0, 1, 0, "sw");
    txn(1, 0, 3'b001, 32'h00000002, 32'h0, 32'h8001ABCD, 5'd16, 0, 0, 0, "lh_neg");
    txn(1, 0, 3'b100, 32'h00000001, 32'h0, 32'h0000F000, 5'd17, 0, 0, 0, "lbu");

    // Random requests, biased toward legal and aligned accesses.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      ren  = (kind == 1) || (kind >= 2 && kind <= 5);
      wen  = (kind == 1) || (kind >= 6);
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      txn(ren, wen, f3, addr, $urandom, $urandom, 5'($urandom_range(0, 31)),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), "rand");
    end

    // Reset while in WAIT, then stale responses must be ignored.
    in_valid = 1'b1; in_ren = 1'b1; in_wen = 1'b0; in_func3 = 3'b010;
    in_addr = 32'h00000100; in_tag = 5'd21;
    step();
    in_valid = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("rstwait/out_valid", 32'(out_valid), 32'd0);
    check("rstwait/in_ready",  32'(in_ready), 32'd1);
    check("rstwait/mem_valid", 32'(mem_valid), 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      step();
      check("stale/out_valid", 32'(out_valid), 32'd0);
      check("stale/in_ready",  32'(in_ready), 32'd1);
      check("stale/mem_valid", 32'(mem_valid), 32'd0);
    end
    mem_rvalid = 1'b0;
    txn(1, 0, 3'b000, 32'h00000102, 32'h0, 32'h00440000, 5'd22, 0, 0, 0, "after_rst");

    // Response withheld in WAIT.
    in_valid = 1'b1; in_ren = 1'b1; in_wen = 1'b0; in_func3 = 3'b010;
    in_addr = 32'h00000200; in_tag = 5'd23;
    step();
    in_valid = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
`ifdef LSU_TIMEOUT_EN
    for (int j = 0; j < 8; j++) begin
      check("tmo/out_valid_wait", 32'(out_valid), 32'd0);
      step();
    end
    check("tmo/out_valid", 32'(out_valid), 32'd1);
    check("tmo/out_err",   32'(out_err), 32'd1);
    check("tmo/out_rdata", out_rdata, 32'd0);
    check("tmo/out_tag",   32'(out_tag), 32'd23);
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_rvalid = 1'b0;
    check("tmo/late_rdata", out_rdata, 32'd0);
    check("tmo/late_err",   32'(out_err), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("tmo/idle", 32'(in_ready), 32'd1);
`else
    for (int j = 0; j < 20; j++) begin
      check("hold/out_valid_wait", 32'(out_valid), 32'd0);
      check("hold/in_ready_wait",  32'(in_ready), 32'd0);
      step();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    mem_rvalid = 1'b0;
    check("hold/out_valid", 32'(out_valid), 32'd1);
    check("hold/out_err",   32'(out_err), 32'd0);
    check("hold/out_rdata", out_rdata, 32'h0BADF00D);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold/idle", 32'(in_ready), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
